// File: rtl/lm32_wb_arb_pkg.sv
// Shared definitions for the LM32 Wishbone arbiter: cycle/burst type codes,
// arbiter state encoding and a constant-safe ceil(log2) helper.
package lm32_wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_ABORT   = 2'd2
  } arb_state_t;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lm32_rr_picker.sv
// Combinational request picker: fixed priority (lowest index) or round-robin
// starting just after the previous winner. Produces a one-hot winner.
module lm32_rr_picker
  import lm32_wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int RR_MODE     = 0,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] winner
);

  logic             found;
  logic [IDX_W-1:0] sel;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (RR_MODE != 0) sel = IDX_W'((int'(last_grant) + 1 + i) % NUM_MASTERS);
      else              sel = IDX_W'(i);
      if (!found && req[sel]) begin
        winner[sel] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lm32_wb_arbiter.sv
// N-master to 1-slave Wishbone arbiter for LM32: holds the grant for a whole
// Wishbone cycle and aborts hung slave cycles with ERR via a watchdog.
module lm32_wb_arbiter
  import lm32_wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_ADR_I,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_DAT_I,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] M_SEL_I,
  input  logic [NUM_MASTERS-1:0]            M_WE_I,
  input  logic [NUM_MASTERS-1:0]            M_CYC_I,
  input  logic [NUM_MASTERS-1:0]            M_STB_I,
  input  logic [NUM_MASTERS-1:0]            M_LOCK_I,
  input  logic [NUM_MASTERS*3-1:0]          M_CTI_I,
  input  logic [NUM_MASTERS*2-1:0]          M_BTE_I,
  output logic [DATA_WIDTH-1:0]             M_DAT_O,
  output logic [NUM_MASTERS-1:0]            M_ACK_O,
  output logic [NUM_MASTERS-1:0]            M_ERR_O,
  output logic [NUM_MASTERS-1:0]            M_RTY_O,
  output logic [ADDR_WIDTH-1:0]             S_ADR_O,
  output logic [DATA_WIDTH-1:0]             S_DAT_O,
  output logic [DATA_WIDTH/8-1:0]           S_SEL_O,
  output logic                              S_WE_O,
  output logic                              S_CYC_O,
  output logic                              S_STB_O,
  output logic [2:0]                        S_CTI_O,
  output logic                              S_LOCK_O,
  output logic [1:0]                        S_BTE_O,
  input  logic [DATA_WIDTH-1:0]             S_DAT_I,
  input  logic                              S_ACK_I,
  input  logic                              S_ERR_I,
  input  logic                              S_RTY_I,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = (clog2(NUM_MASTERS) > 0) ? clog2(NUM_MASTERS) : 1;
  localparam int CNT_W     = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int TO_MAX    = (TIMEOUT > 0) ? TIMEOUT : 0;

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       wd_cnt_q, wd_cnt_d;

  logic [NUM_MASTERS-1:0] winner;
  logic [IDX_W-1:0]       winner_idx;
  logic                   cyc_g;
  logic                   stb_g;
  logic                   slave_term;
  logic                   bus_live;
  logic                   wd_expire;

  lm32_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .RR_MODE     (RR_MODE),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req        (M_CYC_I),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  always_comb begin
    winner_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (winner[k]) winner_idx = IDX_W'(k);
    end
  end

  // Slave bus mirrors the granted master; all zero when nobody holds the grant.
  always_comb begin
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    S_SEL_O  = '0;
    S_WE_O   = 1'b0;
    S_CTI_O  = '0;
    S_LOCK_O = 1'b0;
    S_BTE_O  = '0;
    cyc_g    = 1'b0;
    stb_g    = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        S_ADR_O  = M_ADR_I[k*ADDR_WIDTH +: ADDR_WIDTH];
        S_DAT_O  = M_DAT_I[k*DATA_WIDTH +: DATA_WIDTH];
        S_SEL_O  = M_SEL_I[k*SEL_WIDTH +: SEL_WIDTH];
        S_WE_O   = M_WE_I[k];
        S_CTI_O  = M_CTI_I[k*3 +: 3];
        S_LOCK_O = M_LOCK_I[k];
        S_BTE_O  = M_BTE_I[k*2 +: 2];
        cyc_g    = M_CYC_I[k];
        stb_g    = M_STB_I[k];
      end
    end
    // An aborted cycle is hidden from the slave until the master gives up.
    S_CYC_O = cyc_g && (state_q == ARB_GRANTED);
    S_STB_O = stb_g && (state_q == ARB_GRANTED);
  end

  assign slave_term = S_ACK_I | S_ERR_I | S_RTY_I;
  // Terminations are suppressed while reset is asserted so a dropped cycle never completes.
  assign bus_live   = (state_q == ARB_GRANTED) && !rst_i;
  assign wd_expire  = (TIMEOUT > 0) && (state_q == ARB_GRANTED) && S_STB_O &&
                      !slave_term && (wd_cnt_q == CNT_W'(TO_LAST));

  assign M_DAT_O = S_DAT_I;
  assign M_ACK_O = grant_q & {NUM_MASTERS{bus_live & S_ACK_I}};
  assign M_ERR_O = grant_q & {NUM_MASTERS{bus_live & (S_ERR_I | wd_expire)}};
  assign M_RTY_O = grant_q & {NUM_MASTERS{bus_live & S_RTY_I}};
  assign grant_o = grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (|M_CYC_I) begin
          state_d      = ARB_GRANTED;
          grant_d      = winner;
          last_grant_d = winner_idx;
        end
      end
      ARB_GRANTED: begin
        if (!cyc_g) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end else if (wd_expire) begin
          state_d = ARB_ABORT;
        end else if ((TIMEOUT > 0) && S_STB_O && !slave_term &&
                     (wd_cnt_q != CNT_W'(TO_MAX))) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      ARB_ABORT: begin
        if (!cyc_g) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_lm32_wb_arbiter.sv
// Bench for lm32_wb_arbiter: a fixed-priority instance (TIMEOUT=8) and a round-robin
// instance (watchdog off) share stimulus and are checked against an ownership model.
module tb_lm32_wb_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [N*SW-1:0]   m_sel;
  logic [N-1:0]      m_we, m_cyc, m_stb, m_lock;
  logic [N*3-1:0]    m_cti;
  logic [N*2-1:0]    m_bte;
  logic [DW-1:0]     s_dat;
  logic              s_ack, s_err, s_rty;

  logic [DW-1:0]     mdo   [2];
  logic [N-1:0]      ack_o [2];
  logic [N-1:0]      err_o [2];
  logic [N-1:0]      rty_o [2];
  logic [N-1:0]      gnt   [2];
  logic [AW-1:0]     sadr  [2];
  logic [DW-1:0]     sdat  [2];
  logic [SW-1:0]     ssel  [2];
  logic              swe   [2];
  logic              scyc  [2];
  logic              sstb  [2];
  logic              slock [2];
  logic [2:0]        scti  [2];
  logic [1:0]        sbte  [2];

  lm32_wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .RR_MODE(0), .TIMEOUT(8)) u_fix (
    .clk_i(clk), .rst_i(rst),
    .M_ADR_I(m_adr), .M_DAT_I(m_dat), .M_SEL_I(m_sel), .M_WE_I(m_we),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_LOCK_I(m_lock), .M_CTI_I(m_cti), .M_BTE_I(m_bte),
    .M_DAT_O(mdo[0]), .M_ACK_O(ack_o[0]), .M_ERR_O(err_o[0]), .M_RTY_O(rty_o[0]),
    .S_ADR_O(sadr[0]), .S_DAT_O(sdat[0]), .S_SEL_O(ssel[0]), .S_WE_O(swe[0]),
    .S_CYC_O(scyc[0]), .S_STB_O(sstb[0]), .S_CTI_O(scti[0]), .S_LOCK_O(slock[0]),
    .S_BTE_O(sbte[0]), .S_DAT_I(s_dat), .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_RTY_I(s_rty),
    .grant_o(gnt[0])
  );

  lm32_wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .RR_MODE(1), .TIMEOUT(0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .M_ADR_I(m_adr), .M_DAT_I(m_dat), .M_SEL_I(m_sel), .M_WE_I(m_we),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_LOCK_I(m_lock), .M_CTI_I(m_cti), .M_BTE_I(m_bte),
    .M_DAT_O(mdo[1]), .M_ACK_O(ack_o[1]), .M_ERR_O(err_o[1]), .M_RTY_O(rty_o[1]),
    .S_ADR_O(sadr[1]), .S_DAT_O(sdat[1]), .S_SEL_O(ssel[1]), .S_WE_O(swe[1]),
    .S_CYC_O(scyc[1]), .S_STB_O(sstb[1]), .S_CTI_O(scti[1]), .S_LOCK_O(slock[1]),
    .S_BTE_O(sbte[1]), .S_DAT_I(s_dat), .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_RTY_I(s_rty),
    .grant_o(gnt[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model of each instance: who owns the bus (-1 = nobody), whether the cycle was
  // aborted, how many unanswered strobe cycles have elapsed, and the last winner.
  int own   [2];
  int stall [2];
  int last  [2];
  bit abrt  [2];

  function automatic int to_of(input int d);
    return (d == 0) ? 8 : 0;
  endfunction

  function automatic bit term_now();
    return s_ack || s_err || s_rty;
  endfunction

  function automatic bit expire(input int d);
    int o;
    o = own[d];
    if (o < 0 || abrt[d] || to_of(d) == 0) return 1'b0;
    return m_stb[o] && !term_now() && (stall[d] == to_of(d) - 1);
  endfunction

  function automatic int pick(input int d);
    if (d == 0) begin
      for (int i = 0; i < N; i++) if (m_cyc[i]) return i;
    end else begin
      for (int i = 1; i <= N; i++) if (m_cyc[(last[d] + i) % N]) return (last[d] + i) % N;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic [N-1:0] oh;
    int o;
    bit act, live, wd;
    o    = own[d];
    oh   = '0;
    if (o >= 0) oh[o] = 1'b1;
    act  = (o >= 0) && !abrt[d];
    live = act && !rst;
    wd   = expire(d);
    check($sformatf("d%0d_grant", d), gnt[d], oh);
    check($sformatf("d%0d_s_cyc", d), scyc[d], act ? m_cyc[o] : 1'b0);
    check($sformatf("d%0d_s_stb", d), sstb[d], act ? m_stb[o] : 1'b0);
    check($sformatf("d%0d_s_adr", d), sadr[d], (o >= 0) ? m_adr[o*AW +: AW] : '0);
    check($sformatf("d%0d_s_dat", d), sdat[d], (o >= 0) ? m_dat[o*DW +: DW] : '0);
    check($sformatf("d%0d_s_sel", d), ssel[d], (o >= 0) ? m_sel[o*SW +: SW] : '0);
    check($sformatf("d%0d_s_we", d),  swe[d],  (o >= 0) ? m_we[o] : 1'b0);
    check($sformatf("d%0d_s_lock", d), slock[d], (o >= 0) ? m_lock[o] : 1'b0);
    check($sformatf("d%0d_s_cti", d), scti[d], (o >= 0) ? m_cti[o*3 +: 3] : '0);
    check($sformatf("d%0d_s_bte", d), sbte[d], (o >= 0) ? m_bte[o*2 +: 2] : '0);
    check($sformatf("d%0d_m_ack", d), ack_o[d], (live && s_ack) ? oh : '0);
    check($sformatf("d%0d_m_err", d), err_o[d], (live && (s_err || wd)) ? oh : '0);
    check($sformatf("d%0d_m_rty", d), rty_o[d], (live && s_rty) ? oh : '0);
    check($sformatf("d%0d_m_dat", d), mdo[d], s_dat);
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      int o;
      o = own[d];
      if (rst) begin
        own[d] = -1; abrt[d] = 1'b0; stall[d] = 0; last[d] = N - 1;
      end else if (o < 0) begin
        int w;
        w = pick(d);
        if (w >= 0) begin own[d] = w; last[d] = w; stall[d] = 0; end
      end else if (!m_cyc[o]) begin
        own[d] = -1; abrt[d] = 1'b0; stall[d] = 0;
      end else if (abrt[d]) begin
        stall[d] = 0;
      end else if (expire(d)) begin
        abrt[d] = 1'b1; stall[d] = 0;
      end else if (m_stb[o] && !term_now() && to_of(d) > 0) begin
        stall[d] = (stall[d] + 1 > to_of(d)) ? to_of(d) : stall[d] + 1;
      end else begin
        stall[d] = 0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  initial begin
    int prev, rr_seen, prev_g;
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0; s_dat = '0;
    quiet();
    for (int d = 0; d < 2; d++) begin own[d] = -1; abrt[d] = 0; stall[d] = 0; last[d] = N - 1; end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sample();
    check("reset_grant_fix", gnt[0], '0);
    check("reset_cyc_fix", scyc[0], 1'b0);
    tick();

    // Single read by master 1.
    m_cyc = 2'b10; m_stb = 2'b10; m_adr[AW +: AW] = 32'h0000_1000; m_sel[SW +: SW] = 4'hF;
    sample(); tick();
    s_ack = 1'b1; s_dat = 32'hDEADBEEF;
    sample();
    check("read_s_cyc", scyc[0], 1'b1);
    check("read_s_adr", sadr[0], 32'h0000_1000);
    check("read_ack", ack_o[0], 2'b10);
    check("read_dat", mdo[0], 32'hDEADBEEF);
    tick();
    quiet(); sample(); tick(); sample(); tick();

    // Fixed priority with both masters requesting; master 0 releases at cycle 5.
    m_cyc = 2'b11;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) m_cyc[0] = 1'b0;
      sample();
      if (c == 1) check("fixed_c1_grant", gnt[0], 2'b01);
      if (c == 6) check("fixed_c6_grant", gnt[0], 2'b00);
      if (c == 7) check("fixed_c7_grant", gnt[0], 2'b10);
      tick();
    end
    quiet(); sample(); tick(); sample(); tick();

    // Round-robin with 1-beat cycles: each master drops CYC after its acked beat.
    s_ack = 1'b1; m_stb = 2'b11;
    prev = own[1]; rr_seen = 0; prev_g = 0;
    for (int c = 0; c < 13; c++) begin
      m_cyc[0] = (prev != 0);
      m_cyc[1] = (prev != 1);
      sample();
      if (gnt[1] != 0 && prev_g == 0 && rr_seen < 4) begin
        check("rr_seq", gnt[1], (rr_seen % 2 == 0) ? 2'b01 : 2'b10);
        rr_seen++;
      end
      prev_g = int'(gnt[1]);
      prev   = own[1];
      tick();
    end
    check("rr_grant_count", rr_seen, 4);
    quiet(); sample(); tick(); sample(); tick();

    // 4-beat INCR burst by master 0 while master 1 waits.
    m_cyc = 2'b11; m_stb = 2'b11; m_cti[0 +: 3] = lm32_wb_arb_pkg::CTI_INCR;
    sample(); tick();
    for (int c = 1; c <= 7; c++) begin
      s_ack = (c <= 4);
      if (c == 4) m_cti[0 +: 3] = lm32_wb_arb_pkg::CTI_END;
      if (c == 5) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      sample();
      if (c <= 5) check("burst_hold", gnt[0], 2'b01);
      if (c <= 4) check("burst_cti", scti[0], (c == 4) ? 3'b111 : 3'b010);
      if (c == 6) check("burst_gap", gnt[0], 2'b00);
      if (c == 7) check("burst_next", gnt[0], 2'b10);
      tick();
    end
    quiet(); m_cti = '0; sample(); tick(); sample(); tick();

    // Watchdog: slave never answers master 1.
    m_cyc = 2'b10; m_stb = 2'b10;
    for (int c = 0; c < 14; c++) begin
      if (c == 12) begin m_cyc = '0; m_stb = '0; end
      sample();
      if (c >= 1 && c <= 9) check("wd_err", err_o[0], (c == 8) ? 2'b10 : 2'b00);
      if (c == 9) check("wd_abort_cyc", scyc[0], 1'b0);
      if (c == 11) check("wd_abort_hold", gnt[0], 2'b10);
      if (c == 13) check("wd_idle", gnt[0], 2'b00);
      tick();
    end
    sample(); tick();

    // Reset mid-cycle while master 0 owns the round-robin bus.
    m_cyc = 2'b01; m_stb = 2'b01;
    sample(); tick(); sample(); tick();
    rst = 1'b1; m_cyc = 2'b11; m_stb = 2'b11;
    sample(); tick();
    rst = 1'b0;
    sample();
    check("rst_grant_fix", gnt[0], 2'b00);
    check("rst_grant_rr", gnt[1], 2'b00);
    check("rst_cyc", scyc[0], 1'b0);
    check("rst_term", {ack_o[0], err_o[0], ack_o[1], err_o[1]}, 8'h00);
    tick();
    sample();
    check("rst_rr_favours_m0", gnt[1], 2'b01);
    tick();
    quiet(); sample(); tick(); sample(); tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if (m_cyc[k]) m_cyc[k] = ($urandom_range(0, 5) != 0);
        else          m_cyc[k] = ($urandom_range(0, 2) == 0);
        m_stb[k]  = m_cyc[k] && ($urandom_range(0, 3) != 0);
        m_we[k]   = 1'($urandom);
        m_lock[k] = 1'($urandom);
        m_adr[k*AW +: AW] = $urandom;
        m_dat[k*DW +: DW] = $urandom;
        m_sel[k*SW +: SW] = 4'($urandom);
        m_cti[k*3 +: 3]   = 3'($urandom);
        m_bte[k*2 +: 2]   = 2'($urandom);
      end
      s_ack = ($urandom_range(0, 2) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_rty = ($urandom_range(0, 15) == 0);
      s_dat = $urandom;
      sample();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lm32_wb_arbiter.md
Name: lm32_wb_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone arbiter.
- Merges the LM32 instruction master, the data master and any extra bus masters (for example a DMA engine) onto a single shared Wishbone bus, so the CPU top needs only one external master port.
- Supports fixed-priority or round-robin grant and holds the grant for a whole Wishbone cycle, including bursts and locked transfers.
- Includes a watchdog that terminates hung slave cycles with ERR.

Parameters:
- NUM_MASTERS, 2, number of masters (2..8); index 0 = instruction, 1 = data.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; the SEL width is DATA_WIDTH/8.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 255, cycles without ACK/ERR/RTY before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; the one clock of the block.
- rst_i  in  1  reset, synchronous, active-high.
- M_ADR_I  in  NUM_MASTERS*ADDR_WIDTH  master addresses, master k at slice k.
- M_DAT_I  in  NUM_MASTERS*DATA_WIDTH  master write data.
- M_SEL_I  in  NUM_MASTERS*DATA_WIDTH/8  byte selects.
- M_WE_I, M_CYC_I, M_STB_I, M_LOCK_I  in  NUM_MASTERS each  per-master controls.
- M_CTI_I  in  NUM_MASTERS*3  cycle types.
- M_BTE_I  in  NUM_MASTERS*2  burst types.
- M_DAT_O  out  DATA_WIDTH  read data, broadcast to all masters.
- M_ACK_O, M_ERR_O, M_RTY_O  out  NUM_MASTERS each  per-master termination.
- S_ADR_O, S_DAT_O, S_SEL_O, S_WE_O, S_CYC_O, S_STB_O, S_CTI_O, S_LOCK_O, S_BTE_O  out  matching widths  slave-side bus.
- S_DAT_I  in  DATA_WIDTH  slave read data.
- S_ACK_I, S_ERR_I, S_RTY_I  in  1 each  slave termination.
- grant_o  out  NUM_MASTERS  one-hot current grant, for debug/trace.

Behaviour:
- State machine with states IDLE, GRANTED and ABORT.
- Reset:
  - State goes to IDLE and grant_o to 0.
  - S_CYC_O, S_STB_O, S_WE_O, S_LOCK_O, all M_ACK_O/M_ERR_O/M_RTY_O go to 0.
  - S_ADR_O, S_DAT_O, S_SEL_O, S_CTI_O and S_BTE_O go to 0.
  - Watchdog counter goes to 0.
  - The round-robin pointer (last_grant) goes to NUM_MASTERS-1, so master 0 has first priority.
  - A reset mid-cycle drops the slave cycle at that edge; no termination is sent to the master.
- IDLE:
  - If any M_CYC_I is high, the picker selects a winner. At the next edge grant_o is set one-hot and state goes to GRANTED.
  - Arbitration latency is 1 cycle: request at cycle n, slave sees CYC at n+1.
- Picker:
  - Fixed mode: lowest requesting index wins.
  - RR mode: the first requester at or after last_grant+1, searching modulo NUM_MASTERS, wins.
  - last_grant is updated to the winner when the grant is issued.
- GRANTED:
  - All S_* outputs combinationally mirror the granted master's slice. When no grant is active, S_* outputs are 0.
  - S_ACK_I, S_ERR_I and S_RTY_I route only to the granted master's M_*_O bit; other bits stay 0.
  - M_DAT_O = S_DAT_I at all times.
  - The grant is held while the granted M_CYC_I stays high. This covers incrementing bursts (CTI=010 until 111), STB gaps and LOCK sequences; no re-arbitration happens mid-cycle.
  - When the granted M_CYC_I goes low, state returns to IDLE at the next edge and grant_o clears. There is always 1 dead cycle between grants.
- Watchdog, active when TIMEOUT>0:
  - The counter increments each GRANTED cycle with S_STB_O high and no ACK/ERR/RTY.
  - It clears on any termination, when STB is low, and on grant change.
  - When the count equals TIMEOUT-1 with no termination in that cycle, M_ERR_O of the granted master pulses for exactly that cycle and state goes to ABORT.
- ABORT:
  - S_CYC_O and S_STB_O are forced to 0, and slave terminations are ignored.
  - The block stays in ABORT until the granted M_CYC_I goes low, then goes to IDLE.
- Simultaneous events:
  - A slave ACK in the same cycle as watchdog expiry takes precedence: the ACK is passed through and there is no abort.
  - A new request arriving in the same cycle as a release is arbitrated in the following IDLE cycle.
- Widths: the counter is clog2(TIMEOUT+1) bits and saturates; it cannot wrap.

Decomposition:
- Package lm32_wb_arb_pkg holds:
  - CTI constants: CLASSIC=000, CONST=001, INCR=010, END=111.
  - BTE constants.
  - State encoding: IDLE, GRANTED, ABORT.
  - Helper function clog2.
- Sub-module lm32_rr_picker, which is purely combinational:
  - Inputs: req[NUM_MASTERS], last_grant, RR_MODE.
  - Output: one-hot winner.
  - It is reused by future peripheral arbiters.

Test Plan:
- Single master 1 read at 0x0000_1000: CYC at cycle 0, so S_CYC_O=1 at cycle 1 with S_ADR_O=0x1000. The slave acks with 0xDEADBEEF; only M_ACK_O[1]=1, and M_DAT_O=0xDEADBEEF.
- Fixed mode, masters 0 and 1 both request at cycle 0: grant_o=01 at cycle 1. Master 0 releases at cycle 5, so grant_o=00 at cycle 6 and grant_o=10 at cycle 7.
- RR mode, both masters requesting continuously with 1-beat cycles: the grant sequence is 01, 10, 01, 10, with one idle cycle between grants.
- Master 0 performs a 4-beat INCR burst (CTI 010,010,010,111) while master 1 requests: master 1 is not granted until master 0 drops CYC after the 4th ACK.
- TIMEOUT=8, the slave never acks: M_ERR_O pulses for exactly 1 cycle, 8 STB cycles after the grant. S_CYC_O=0 from the next cycle until the master drops CYC, then IDLE.
- Assert rst_i for 1 cycle in the middle of a granted cycle: at the next edge grant_o=0, S_CYC_O=0 and no ACK/ERR is seen; the next arbitration favours master 0.
